// File: rtl/rc4_pkg.sv
// Shared constants and state encoding for the decrypted-message checker.
package rc4_pkg;

  localparam int MSG_LEN_DEF = 32;

  // Legal plaintext alphabet: lowercase letters plus space.
  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } chk_state_e;

endpackage

// File: rtl/rc4_char_is_valid.sv
// Combinational legality test for one decrypted byte.
module rc4_char_is_valid
  import rc4_pkg::*;
(
  input  logic [7:0] ch_i,
  output logic       legal_o
);

  // A byte is legal if it is a lowercase letter or a space.
  assign legal_o = ((ch_i >= CHAR_A) && (ch_i <= CHAR_Z)) || (ch_i == CHAR_SPACE);

endmodule

// File: rtl/decrypted_message_checker.sv
// Walks the decrypted-message RAM byte by byte and reports whether every
// byte is plaintext. Stops at the first illegal byte and records its address.
module decrypted_message_checker
  import rc4_pkg::*;
#(
  parameter int MSG_LEN      = MSG_LEN_DEF,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] Decrypted_Message_q,
  output logic [4:0] Decrypted_Message_address,
  output logic       Decrypted_Message_wren,
  output logic       busy,
  output logic       done,
  output logic       msg_valid,
  output logic       msg_invalid,
  output logic [4:0] fail_index
);

  localparam int         LW        = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LATENCY - 1);
  localparam logic [4:0] ADDR_LAST = 5'(MSG_LEN - 1);

  chk_state_e    state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          ok_q, ok_d;
  logic          bad_q, bad_d;
  logic [4:0]    fidx_q, fidx_d;
  logic          legal;

  rc4_char_is_valid u_char_is_valid (
    .ch_i    (Decrypted_Message_q),
    .legal_o (legal)
  );

  // Next-state: one byte per ISSUE/WAIT/CHECK round trip, early exit on a bad byte.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    ok_d    = ok_q;
    bad_d   = bad_q;
    fidx_d  = fidx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          addr_d  = 5'd0;
          ok_d    = 1'b0;
          bad_d   = 1'b0;
          fidx_d  = 5'd0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        lat_d   = '0;
      end
      ST_WAIT: begin
        // Address stays put while the RAM read completes.
        if (lat_q == LAT_LAST) state_d = ST_CHECK;
        else                   lat_d   = lat_q + 1'b1;
      end
      ST_CHECK: begin
        if (!legal) begin
          state_d = ST_DONE;
          bad_d   = 1'b1;
          fidx_d  = addr_q;
        end else if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
          ok_d    = 1'b1;
        end else begin
          state_d = ST_ISSUE;
          addr_d  = addr_q + 5'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and result registers; reset aborts any pass and clears results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 5'd0;
      lat_q   <= '0;
      ok_q    <= 1'b0;
      bad_q   <= 1'b0;
      fidx_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      ok_q    <= ok_d;
      bad_q   <= bad_d;
      fidx_q  <= fidx_d;
    end
  end

  assign Decrypted_Message_address = addr_q;
  assign Decrypted_Message_wren    = 1'b0;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign msg_valid   = ok_q;
  assign msg_invalid = bad_q;
  assign fail_index  = fidx_q;

endmodule

// File: doc/decrypted_message_checker.md
DECRYPTED_MESSAGE_CHECKER -- requirements
Module: decrypted_message_checker

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter MSG_LEN, default 32, number of decrypted message bytes checked.
REQ-003 Parameter READ_LATENCY, default 1, clock edges from address driven to q valid.
REQ-004 clk  in  1  system clock, all flops rising-edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request a check pass; sampled only in IDLE.
REQ-007 Decrypted_Message_q  in  8  read data from decrypted message RAM.
REQ-008 Decrypted_Message_address  out  5  read address to decrypted message RAM.
REQ-009 Decrypted_Message_wren  out  1  write enable, constant 0 (read-only master).
REQ-010 busy  out  1  high from ISSUE entry until DONE exit.
REQ-011 done  out  1  one-cycle pulse when a pass completes.
REQ-012 msg_valid  out  1  high when last pass found every byte legal; held until next start.
REQ-013 msg_invalid  out  1  high when last pass hit an illegal byte; held until next start.
REQ-014 fail_index  out  5  address of first illegal byte; 0 on pass.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT, CHECK, DONE.
REQ-016 IDLE: start=1 -> ISSUE, address cleared to 0, msg_valid/msg_invalid/fail_index cleared.
REQ-017 ISSUE: drives current address for one cycle -> WAIT.
REQ-018 WAIT: counts READ_LATENCY cycles, address held stable -> CHECK.
REQ-019 CHECK: byte legal iff 8'h61..8'h7A (a-z) or 8'h20 (space).
REQ-020 CHECK illegal -> DONE, msg_invalid=1, fail_index=address, early exit.
REQ-021 CHECK legal and address==MSG_LEN-1 -> DONE, msg_valid=1.
REQ-022 CHECK legal otherwise -> address+1, ISSUE; no wrap since last address exits.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 Per-byte cost SHALL be 2+READ_LATENCY cycles.
REQ-025 With start sampled at edge k, done SHALL be high in cycle k+1+(2+READ_LATENCY)*n, n = bytes checked.
REQ-026 start while busy or in DONE SHALL be ignored, no queuing.
REQ-027 msg_valid and msg_invalid SHALL never be high together.
REQ-028 Decrypted_Message_wren SHALL be 0 in every state including reset.

Reset
REQ-029 reset_n low SHALL force IDLE, address 0, busy 0, done 0, msg_valid 0, msg_invalid 0, fail_index 0.
REQ-030 Reset mid-pass SHALL abort with no done pulse; results stay cleared.
REQ-031 After release, first start SHALL be accepted on the first clk edge.

Structure
REQ-032 Shared package rc4_pkg SHALL hold MSG_LEN default, CHAR_A/CHAR_Z/CHAR_SPACE constants, and the checker state enum.
REQ-033 One sub-module rc4_char_is_valid (8-bit in, 1-bit out, combinational) SHALL hold the legality rule.
REQ-034 Address counter, latency counter and FSM SHALL live in decrypted_message_checker.

Verification
REQ-035 RAM preloaded "attack at dawn" padded with spaces to 32, start pulse -> done at cycle k+97, msg_valid=1, fail_index=0.
REQ-036 Byte 0 = 8'h41 ('A'), start -> done at cycle k+4, msg_invalid=1, fail_index=0.
REQ-037 Byte 31 = 8'h7B, rest legal -> msg_invalid=1, fail_index=31; edges 8'h61/8'h7A/8'h20 pass, 8'h60/8'h1F fail.
REQ-038 start held high through a whole pass -> exactly one done, then second pass begins the cycle after return to IDLE.
REQ-039 reset_n low at cycle k+40 -> all outputs 0 asynchronously, no done, next start runs full pass.
REQ-040 READ_LATENCY=2 build, all-legal RAM -> done at cycle k+129, wren 0 throughout.
